// File: rtl/data_mem_be.sv
// data_mem_be: single-port 32-bit data memory with byte/halfword/word access,
// byte-lane stores, sign/zero-extended loads and a one-cycle registered
// response. Misaligned, illegal-size or out-of-range requests return an
// error and leave memory untouched.
//
// Optional feature: define DATA_MEM_INIT_CLEAR_EN to enable a clear sweep
// after reset. The sweep writes zero to every word, one word per cycle, and
// holds req_ready low while it runs. Without the macro the block enters RUN
// on the first clock edge after reset, and memory is undefined until written.
//
// Handshake: a request transfers on a rising edge where req_valid and
// req_ready are both 1. Its response is presented for exactly one cycle,
// starting at the next edge (rsp_valid=1), and cannot be stalled.
module data_mem_be #(
   parameter int DEPTH = 256,
   parameter int AW    = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic          req_we,
   input  logic [1:0]    req_size,
   input  logic          req_unsigned,
   input  logic [AW-1:0] req_addr,
   input  logic [31:0]   req_wdata,
   output logic          rsp_valid,
   output logic [31:0]   rsp_rdata,
   output logic          rsp_err,
   output logic          init_busy,
   output logic          dbg_state
);

   localparam int IW = $clog2(DEPTH);
   localparam logic [AW:0] BYTES = (AW+1)'(4 * DEPTH);

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   state_e state_q, state_d;

   logic [31:0] mem_q [DEPTH];

   logic          accept;
   logic          err;
   logic          oor;
   logic          store_en;
   logic [IW-1:0] widx;
   logic [3:0]    lane_be;
   logic [31:0]   lane_wd;
   logic [31:0]   rd_word;
   logic [31:0]   rd_shift;
   logic [31:0]   ld_data;

   logic          mem_we;
   logic [IW-1:0] mem_idx;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wd;

   logic          rsp_valid_q, rsp_valid_d;
   logic          rsp_err_q, rsp_err_d;
   logic [31:0]   rsp_rdata_q, rsp_rdata_d;

`ifdef DATA_MEM_INIT_CLEAR_EN
   logic [IW-1:0] sweep_cnt_q, sweep_cnt_d;
   logic          sweep_last;
   logic          sweep_we;

   // Sweep counter: starts at word 0 on reset, advances once per INIT cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) sweep_cnt_q <= '0;
      else     sweep_cnt_q <= sweep_cnt_d;
   end

   // Next sweep counter value.
   always_comb begin
      sweep_cnt_d = sweep_cnt_q;
      if (state_q == ST_INIT) sweep_cnt_d = sweep_cnt_q + 1'b1;
   end

   assign sweep_last = (sweep_cnt_q == IW'(DEPTH - 1));
   // No clearing while reset is held; the sweep starts once rst drops.
   assign sweep_we   = (state_q == ST_INIT) && !rst;
`endif

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= ST_INIT;
      else     state_q <= state_d;
   end

   // FSM next state: INIT leaves after the last sweep word (or at once when
   // there is no sweep); RUN holds until reset.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_INIT: begin
`ifdef DATA_MEM_INIT_CLEAR_EN
            if (sweep_last) state_d = ST_RUN;
`else
            state_d = ST_RUN;
`endif
         end
         ST_RUN:  state_d = ST_RUN;
         default: state_d = ST_INIT;
      endcase
   end

   // FSM outputs.
   always_comb begin
      req_ready = (state_q == ST_RUN);
`ifdef DATA_MEM_INIT_CLEAR_EN
      init_busy = (state_q == ST_INIT);
`else
      init_busy = 1'b0;
`endif
   end

   assign dbg_state = state_q;

   // Request decode: handshake, word index, error classification.
   always_comb begin
      accept   = req_valid && req_ready;
      widx     = req_addr[IW+1:2];
      oor      = ({1'b0, req_addr} >= BYTES);
      err      = oor
               || (req_size == 2'b11)
               || ((req_size == 2'b01) && req_addr[0])
               || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));
      store_en = accept && req_we && !err;
   end

   // Store lane enables and lane-replicated write data.
   always_comb begin
      case (req_size)
         2'b00: begin
            lane_be = 4'b0001 << req_addr[1:0];
            lane_wd = {4{req_wdata[7:0]}};
         end
         2'b01: begin
            lane_be = req_addr[1] ? 4'b1100 : 4'b0011;
            lane_wd = {2{req_wdata[15:0]}};
         end
         default: begin
            lane_be = 4'b1111;
            lane_wd = req_wdata;
         end
      endcase
   end

   // Load path: the array is read in the request cycle, so a store written
   // at the previous edge is already visible to a following load.
   always_comb begin
      rd_word  = mem_q[widx];
      rd_shift = rd_word >> {req_addr[1:0], 3'b000};
      case (req_size)
         2'b00:   ld_data = req_unsigned ? {24'h0, rd_shift[7:0]}
                                         : {{24{rd_shift[7]}}, rd_shift[7:0]};
         2'b01:   ld_data = req_unsigned ? {16'h0, rd_shift[15:0]}
                                         : {{16{rd_shift[15]}}, rd_shift[15:0]};
         default: ld_data = rd_word;
      endcase
   end

   // Memory write port: the clear sweep and request stores share it; they
   // never overlap because requests are refused during INIT.
   always_comb begin
      mem_we  = store_en;
      mem_idx = widx;
      mem_be  = lane_be;
      mem_wd  = lane_wd;
`ifdef DATA_MEM_INIT_CLEAR_EN
      if (sweep_we) begin
         mem_we  = 1'b1;
         mem_idx = sweep_cnt_q;
         mem_be  = 4'b1111;
         mem_wd  = '0;
      end
`endif
   end

   // Memory array: byte-lane writes, never reset.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (mem_be[i]) mem_q[mem_idx][8*i +: 8] <= mem_wd[8*i +: 8];
         end
      end
   end

   // Next response: data only for successful loads, zero otherwise.
   always_comb begin
      rsp_valid_d = accept;
      rsp_err_d   = accept && err;
      rsp_rdata_d = (accept && !req_we && !err) ? ld_data : 32'h0;
   end

   // Response registers; reset drops any response still in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= 32'h0;
      end else begin
         rsp_valid_q <= rsp_valid_d;
         rsp_err_q   <= rsp_err_d;
         rsp_rdata_q <= rsp_rdata_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_err   = rsp_err_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_data_mem_be.sv
// tb_data_mem_be: directed and randomized checks for data_mem_be.
// Expected responses are queued when a request is accepted and compared at
// the following falling edge; a byte-addressed model supplies expectations
// for the randomized section. Sweep checks apply when DATA_MEM_INIT_CLEAR_EN
// is defined.
module tb_data_mem_be;

   localparam int DEPTH = 256;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = 32'h0;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        init_busy;
   logic        dbg_state;

   int n_total = 0;
   int n_bad   = 0;

   logic [32:0] exp_q[$];
   logic [7:0]  mb [logic [31:0]];

   data_mem_be #(.DEPTH(DEPTH), .AW(32)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .rsp_valid    (rsp_valid),
      .rsp_rdata    (rsp_rdata),
      .rsp_err      (rsp_err),
      .init_busy    (init_busy),
      .dbg_state    (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   // Scoreboard: one response is owed at the falling edge after each accept.
   always @(negedge clk) begin
      logic [32:0] e;
      if (rst) begin
         chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
         exp_q.delete();
      end else if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
         chk("rsp_err", {31'b0, rsp_err}, {31'b0, e[32]});
         chk("rsp_rdata", rsp_rdata, e[31:0]);
      end else begin
         chk("spurious_rsp", {31'b0, rsp_valid}, 32'd0);
      end
   end

   function automatic logic m_err(input logic [1:0] sz, input logic [31:0] a);
      return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
             (sz == 2'b10 && a[1:0] != 2'b00) || (a >= 32'(4 * DEPTH));
   endfunction

   function automatic logic [7:0] m_byte(input logic [31:0] a);
      return mb.exists(a) ? mb[a] : 8'h00;
   endfunction

   function automatic logic [31:0] m_load(input logic [1:0] sz, input logic uns,
                                          input logic [31:0] a);
      logic [7:0]  b;
      logic [15:0] h;
      b = m_byte(a);
      h = {m_byte(a + 1), m_byte(a)};
      case (sz)
         2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: return {m_byte(a + 3), m_byte(a + 2), h};
      endcase
   endfunction

   // Present one request for one accepting edge; leaves req_valid low unless
   // the caller immediately issues another request (back-to-back).
   task automatic drive(input logic we, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wd,
                        input logic exp_err, input logic [31:0] exp_rd);
      req_valid = 1'b1;
      req_we = we;
      req_size = sz;
      req_unsigned = uns;
      req_addr = a;
      req_wdata = wd;
      chk("req_ready_at_issue", {31'b0, req_ready}, 32'd1);
      @(posedge clk);
      exp_q.push_back({exp_err, exp_rd});
      if (we && !exp_err) begin
         for (int i = 0; i < (1 << sz); i++) mb[a + 32'(i)] = wd[8*i +: 8];
      end
      #1;
      req_valid = 1'b0;
   endtask

   task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
      drive(1'b1, sz, 1'b0, a, wd, 1'b0, 32'h0);
   endtask

   task automatic ld(input logic [1:0] sz, input logic uns, input logic [31:0] a,
                     input logic [31:0] exp_rd);
      drive(1'b0, sz, uns, a, 32'h0, 1'b0, exp_rd);
   endtask

   task automatic bad(input logic we, input logic [1:0] sz, input logic [31:0] a);
      drive(we, sz, 1'b0, a, 32'hDEAD_BEEF, 1'b1, 32'h0);
   endtask

   task automatic wait_run(output int n);
      n = 0;
      while (req_ready !== 1'b1 && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
   endtask

   task automatic chk_reset_outputs();
      chk("rst_rdata", rsp_rdata, 32'h0);
      chk("rst_err", {31'b0, rsp_err}, 32'd0);
      chk("rst_ready", {31'b0, req_ready}, 32'd0);
`ifdef DATA_MEM_INIT_CLEAR_EN
      chk("rst_busy", {31'b0, init_busy}, 32'd1);
`else
      chk("rst_busy", {31'b0, init_busy}, 32'd0);
`endif
   endtask

   initial begin
      int n;
      logic        r_we, r_uns, r_err;
      logic [1:0]  r_sz;
      logic [31:0] r_a, r_wd, r_rd;

      // Reset
      #1 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_reset_outputs();
      rst = 1'b0;

`ifdef DATA_MEM_INIT_CLEAR_EN
      chk("sweep_busy_start", {31'b0, init_busy}, 32'd1);
      chk("sweep_ready_start", {31'b0, req_ready}, 32'd0);
      repeat (100) @(posedge clk);
      #1;
      chk("sweep_busy_mid", {31'b0, init_busy}, 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk_reset_outputs();
      rst = 1'b0;
      wait_run(n);
      chk("sweep_restart_cycles", n, DEPTH);
      chk("busy_after_sweep", {31'b0, init_busy}, 32'd0);
      ld(2'b10, 1'b0, 32'h3FC, 32'h0);
      ld(2'b00, 1'b0, 32'h37, 32'h0);
`else
      chk("ready_before_edge", {31'b0, req_ready}, 32'd0);
      wait_run(n);
      chk("run_entry_cycles", n, 1);
      chk("busy_const", {31'b0, init_busy}, 32'd0);
`endif
      chk("ready_in_run", {31'b0, req_ready}, 32'd1);

      // Word store, then lane-selected loads
      st(2'b10, 32'h10, 32'h1122_3344);
      ld(2'b00, 1'b1, 32'h13, 32'h0000_0011);
      ld(2'b00, 1'b0, 32'h12, 32'h0000_0022);
      ld(2'b01, 1'b0, 32'h12, 32'h0000_1122);
      ld(2'b01, 1'b0, 32'h10, 32'h0000_3344);
      repeat (2) @(posedge clk);
      #1;

      // Byte store merges into an existing word
      st(2'b10, 32'h20, 32'hAABB_CCDD);
      st(2'b00, 32'h21, 32'h1234_56F0);
      ld(2'b10, 1'b0, 32'h20, 32'hAABB_F0DD);
      ld(2'b00, 1'b0, 32'h21, 32'hFFFF_FFF0);
      ld(2'b00, 1'b1, 32'h21, 32'h0000_00F0);
      ld(2'b01, 1'b0, 32'h20, 32'hFFFF_F0DD);
      ld(2'b01, 1'b1, 32'h22, 32'h0000_AABB);
      st(2'b01, 32'h22, 32'h5555_8001);
      ld(2'b10, 1'b1, 32'h20, 32'h8001_F0DD);

      // Error cases leave memory unchanged
      st(2'b10, 32'h0, 32'h5A5A_5A5A);
      st(2'b10, 32'h3FC, 32'hCAFE_BABE);
      bad(1'b1, 2'b10, 32'h22);
      bad(1'b1, 2'b01, 32'h23);
      bad(1'b1, 2'b11, 32'h0);
      bad(1'b1, 2'b10, 32'h400);
      bad(1'b0, 2'b10, 32'h400);
      bad(1'b0, 2'b10, 32'h21);
      bad(1'b0, 2'b11, 32'h20);
      bad(1'b0, 2'b01, 32'h8000_0001);
      ld(2'b10, 1'b0, 32'h20, 32'h8001_F0DD);
      ld(2'b10, 1'b0, 32'h0, 32'h5A5A_5A5A);
      ld(2'b10, 1'b0, 32'h3FC, 32'hCAFE_BABE);
      ld(2'b00, 1'b0, 32'h3FF, 32'hFFFF_FFCA);

      // Back-to-back alternating store/load on one word
      st(2'b10, 32'h30, 32'h0102_0304);
      ld(2'b10, 1'b0, 32'h30, 32'h0102_0304);
      st(2'b10, 32'h30, 32'h8765_4321);
      ld(2'b10, 1'b0, 32'h30, 32'h8765_4321);
      st(2'b00, 32'h32, 32'h0000_00EE);
      ld(2'b10, 1'b0, 32'h30, 32'h87EE_4321);
      st(2'b01, 32'h30, 32'h0000_9ABC);
      ld(2'b10, 1'b0, 32'h30, 32'h87EE_9ABC);

      // Randomized traffic over a pre-written region, checked against the model
      for (int i = 0; i < 16; i++) st(2'b10, 32'h40 + 32'(4 * i), $urandom);
      for (int i = 0; i < 60; i++) begin
         r_we  = 1'($urandom_range(0, 1));
         r_sz  = 2'($urandom_range(0, 3));
         r_uns = 1'($urandom_range(0, 1));
         r_wd  = $urandom;
         if ($urandom_range(0, 7) == 0) r_a = 32'h400 + 32'($urandom_range(0, 4095));
         else r_a = 32'h40 + 32'($urandom_range(0, 60));
         r_err = m_err(r_sz, r_a);
         r_rd  = (r_we || r_err) ? 32'h0 : m_load(r_sz, r_uns, r_a);
         drive(r_we, r_sz, r_uns, r_a, r_wd, r_err, r_rd);
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
         end
      end
      repeat (2) @(posedge clk);
      #1;

      // Reset with a response in flight: the response is dropped
      req_valid = 1'b1;
      req_we = 1'b0;
      req_size = 2'b10;
      req_unsigned = 1'b0;
      req_addr = 32'h10;
      @(posedge clk);
      #1;
      rst = 1'b1;
      req_valid = 1'b0;
      #1;
      chk_reset_outputs();
      chk("rst_drop_now", {31'b0, rsp_valid}, 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      wait_run(n);
`ifdef DATA_MEM_INIT_CLEAR_EN
      chk("sweep_after_drop_cycles", n, DEPTH);
      mb.delete();
      ld(2'b10, 1'b0, 32'h10, 32'h0);
`else
      chk("run_after_drop_cycles", n, 1);
      ld(2'b10, 1'b0, 32'h10, 32'h1122_3344);
`endif
      ld(2'b10, 1'b0, 32'h44, m_load(2'b10, 1'b0, 32'h44));

      repeat (3) @(posedge clk);
      #1;
      chk("queue_drained", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/data_mem_be.md
DATA_MEM_BE -- requirements
Module: data_mem_be

Interface
REQ-001 Parameter DEPTH, default 256, SHALL set the number of 32-bit words; it SHALL be a power of two, 4..65536.
REQ-002 Parameter AW, default 32, SHALL set the byte-address width.
REQ-003 Port clk, input, 1: the single clock; all state changes on rising edge.
REQ-004 Port rst, input, 1: asynchronous, active-high reset.
REQ-005 Port req_valid, input, 1: a request is presented.
REQ-006 Port req_ready, output, 1: the block accepts a request this cycle.
REQ-007 Port req_we, input, 1: 1 = store, 0 = load.
REQ-008 Port req_size, input, 2: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-009 Port req_unsigned, input, 1: zero-extend on load when 1, sign-extend when 0.
REQ-010 Port req_addr, input, AW: byte address.
REQ-011 Port req_wdata, input, 32: store data, right-aligned (byte in [7:0], half in [15:0]).
REQ-012 Port rsp_valid, output, 1: response for the request accepted in the previous cycle.
REQ-013 Port rsp_rdata, output, 32: extended load data; 0 for stores and errors.
REQ-014 Port rsp_err, output, 1: the request was misaligned, out of range or illegal-size.
REQ-015 Port init_busy, output, 1: memory-clear sweep in progress.

Function
REQ-016 Handshake: a request SHALL be accepted only in a cycle where req_valid and req_ready are both 1; there is no response backpressure.
REQ-017 Latency: every accepted request SHALL produce exactly one rsp_valid pulse one cycle later, for both loads and stores; back-to-back requests SHALL sustain one per cycle.
REQ-018 Word index SHALL be req_addr[log2(DEPTH)+1:2]; a request SHALL be out of range when req_addr >= 4*DEPTH.
REQ-019 Error conditions: halfword with addr[0]=1, word with addr[1:0]!=0, size=11, or out of range. On error there SHALL be no memory update, and the response SHALL be rsp_err=1 with rsp_rdata=0.
REQ-020 Stores SHALL write only the addressed bytes: byte lane addr[1:0], halfword lanes addr[1]*2..+1, word all four lanes; the other lanes SHALL be preserved.
REQ-021 Loads SHALL select the addressed lane(s), right-align them and extend them per req_unsigned; for size=10, req_unsigned SHALL be ignored.
REQ-022 A load accepted in the cycle after a store to the same word SHALL return the updated data.
REQ-023 FSM states: INIT (sweep), RUN. rst SHALL force INIT with sweep counter 0. INIT SHALL write 0 to word[counter], increment once per cycle, and move to RUN after word DEPTH-1 (DEPTH cycles). RUN SHALL be terminal until rst.
REQ-024 In INIT, req_ready SHALL be 0 and init_busy SHALL be 1; in RUN, req_ready SHALL be 1 and init_busy SHALL be 0.
REQ-025 rst asserted mid-sweep SHALL restart the sweep from word 0; rst asserted with a response pending SHALL drop that response (no rsp_valid).

Reset
REQ-026 While rst=1: rsp_valid=0, rsp_rdata=0, rsp_err=0, req_ready=0, init_busy=1 (0 when the macro is undefined), and the FSM SHALL be in INIT with the counter at 0.
REQ-027 Memory contents SHALL NOT be cleared asynchronously; clearing happens only through the sweep.

Configuration
REQ-028 Macro DATA_MEM_INIT_CLEAR_EN defined: the INIT sweep SHALL behave as REQ-023 to REQ-025.
REQ-029 Macro undefined: there SHALL be no sweep, the FSM SHALL enter RUN on the first clock edge after rst deasserts, init_busy SHALL be constant 0, and memory contents SHALL be undefined until written.

Verification
REQ-030 Deassert rst with the macro defined -> init_busy=1 and req_ready=0 for exactly 256 cycles; then a load of word at 0x3FC returns 0x00000000.
REQ-031 Store word 0x11223344 @0x10, then load byte unsigned @0x13, byte signed @0x12, half signed @0x12 -> responses 0x00000011, 0x00000022, 0x00001122, one cycle after each accept.
REQ-032 Store byte 0xF0 @0x21 over word 0xAABBCCDD @0x20, then word load @0x20 -> 0xAABBF0DD; then signed byte load @0x21 -> 0xFFFFFFF0.
REQ-033 Store word @0x22, halfword @0x23, size=11 @0x0, and word @0x400 with DEPTH=256 -> each gives rsp_err=1, rsp_rdata=0, and memory is unchanged.
REQ-034 Assert rst at sweep cycle 100, release it -> the sweep restarts, init_busy stays high for 256 more cycles, and a pending response is suppressed.
REQ-035 Issue 8 back-to-back alternating store/load requests to the same word -> 8 consecutive rsp_valid pulses, and each load returns the preceding store's data.
